slave_write: RTL and testbench
==============================

# slave_write

AXI write-channel responder for one SRAM-backed slave: the write-side counterpart of `slave_read`. Accepts one AW burst, streams its W beats into the SRAM word port with byte enables from WSTRB, then returns a single B response. Instantiated per slave beside `slave_read`, sharing the SRAM address bus through the slave wrapper's mux.

## Interface
Parameters:
- `SRAM_ADDR_BITS`, 14, SRAM word-address width; `A = addr[SRAM_ADDR_BITS+1:2]`

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-low reset
- `AWID` in `AXI_IDS_BITS` — write address ID
- `AWADDR` in `AXI_ADDR_BITS` — burst start byte address
- `AWLEN` in `AXI_LEN_BITS` — beats minus one (0..15)
- `AWSIZE` in `AXI_SIZE_BITS` — only 3'b010 (4 bytes) legal
- `AWBURST` in 2 — 2'b00 FIXED, 2'b01 INCR; others treated as INCR
- `AWVALID` in 1 / `AWREADY` out 1 — AW handshake
- `WDATA` in `AXI_DATA_BITS`, `WSTRB` in 4, `WLAST` in 1
- `WVALID` in 1 / `WREADY` out 1 — W handshake
- `BID` out `AXI_IDS_BITS`, `BRESP` out 2, `BVALID` out 1, `BREADY` in 1
- `CS` out 1 — SRAM chip select, high in DATA state
- `WEB` out 4 — SRAM byte write enable, active-low
- `A` out `SRAM_ADDR_BITS` — SRAM word address
- `DI` out 32 — SRAM write data
- `slave_id` in 8 — this slave's region tag (AWADDR[31:16] = {8'h00, slave_id})

## Operation
- States: IDLE, DATA, RESP.
- IDLE: `AWREADY=1`. On AWVALID&&AWREADY latch AWID, AWADDR[SRAM_ADDR_BITS+1:2], AWLEN, AWBURST; clear beat counter and error flag; set error if AWSIZE≠3'b010 → DATA.
- DATA: `WREADY=1`, `CS=1`. Each W handshake: `A`=current word address, `DI=WDATA`, `WEB=~WSTRB` in that same cycle; otherwise `WEB=4'hF`. After each beat: INCR → address +1, wraps modulo 2^SRAM_ADDR_BITS; FIXED → unchanged. Beat counter +1, saturates at 15.
- Burst ends on the W handshake carrying WLAST → RESP.
- WLAST on beat ≠ AWLEN → SLVERR. Beats past AWLEN accepted, `WEB=4'hF` (not written).
- Error flag set (bad size): all beats accepted, none written.
- RESP: `BVALID=1`, `BID`=latched AWID, `BRESP`=2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR (see Configuration; DECERR takes priority). Hold stable until BREADY → IDLE.
- `AWREADY=0` outside IDLE; `WREADY=0` outside DATA.
- Reset (asserted any time, including mid-burst): state IDLE immediately; `AWREADY=0`, `WREADY=0`, `BVALID=0`, `BID=0`, `BRESP=0`, `CS=0`, `WEB=4'hF`, `A=0`, `DI=0`; no partial B issued. `AWREADY` rises on first edge after reset release.

## Timing
- AW handshake cycle T0; DATA from T0+1.
- SRAM write is combinational from the W handshake cycle (zero added latency); SRAM captures at the edge ending that cycle.
- Last beat at Tn → BVALID at Tn+1; BREADY high at Tn+1 → IDLE and AWREADY=1 at Tn+2.
- Minimum single-beat transaction: 3 cycles AW-to-next-AWREADY.
- W beats presented during IDLE are not accepted (WREADY=0); WVALID low in DATA inserts idle cycles with `WEB=4'hF`.

## Configuration
- `SLAVE_WRITE_DECERR_EN` defined: at AW handshake, AWADDR[31:16] ≠ {8'h00, slave_id} sets decode-error flag; every beat accepted with `WEB=4'hF`; BRESP=2'b11.
- Undefined: no region check; all in-size bursts written; BRESP only OKAY/SLVERR.

## Structure
- Shared package `axi_slave_pkg`: state enum (IDLE/DATA/RESP, shared with `slave_read`), BRESP/RRESP constants OKAY/SLVERR/DECERR, burst-type constants FIXED/INCR.
- One sub-module `wburst_addr_gen`: holds word address and beat counter, load on AW handshake, advance on W handshake per burst type, outputs `A` and last-beat-expected flag.

## Test plan
- Single beat: AWADDR=0x0001_0010 (slave_id=1), AWLEN=0, WDATA=0xDEADBEEF, WSTRB=4'hF, WLAST=1 → A=0x004, WEB=4'h0 one cycle, BRESP=OKAY, BID=AWID, BVALID one cycle after beat.
- INCR 4 beats, WSTRB=4'b0011, WVALID gap after beat 2 → A=0x004..0x007, WEB=4'b1100 only on handshake cycles, single B OKAY.
- Address wrap: word address 0x3FFF, INCR AWLEN=1 → second beat A=0x0000.
- Early WLAST on beat 1 of AWLEN=3 → 2 writes, BRESP=SLVERR; AWSIZE=3'b001 → no writes, SLVERR.
- BREADY held low 5 cycles → BVALID/BRESP/BID stable, AWREADY=0 throughout; with macro, AWADDR=0x0002_0000 (slave_id=1) → no writes, BRESP=DECERR.
- Reset pulsed during beat 2 of 4 → outputs at reset values immediately, no B, AWREADY=1 one edge after release.

Source files
------------

// File: rtl/axi_slave_pkg.sv
// Shared AXI slave definitions: bus widths, the responder state enum and response/burst encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package axi_slave_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;

  // Common to the read and write responders.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Only 4-byte beats match the 32-bit SRAM word.
  localparam logic [AXI_SIZE_BITS-1:0] SIZE_4B = 3'b010;

  // Decode error outranks slave error.
  function automatic logic [1:0] bresp_sel(input logic dec_err, input logic slv_err);
    return dec_err ? RESP_DECERR : (slv_err ? RESP_SLVERR : RESP_OKAY);
  endfunction

endpackage

// File: rtl/wburst_addr_gen.sv
// Write-burst word address / beat counter: loaded on the AW handshake, stepped on each W handshake.
// Latency: outputs are registers; the new address is visible the cycle after the beat.
// Backpressure: none; advances only when the parent reports a W handshake.
// Ports: clk/rst (async active-low); i_load + i_addr/i_len/i_burst from AW; i_adv per W beat;
//        o_addr = current SRAM word address, o_last_exp = this beat is beat AWLEN,
//        o_past_len = beats beyond AWLEN are now arriving.
module wburst_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int SRAM_ADDR_BITS = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load,
  input  logic [SRAM_ADDR_BITS-1:0] i_addr,
  input  logic [AXI_LEN_BITS-1:0]   i_len,
  input  logic [1:0]                i_burst,
  input  logic                      i_adv,
  output logic [SRAM_ADDR_BITS-1:0] o_addr,
  output logic                      o_last_exp,
  output logic                      o_past_len
);

  logic [SRAM_ADDR_BITS-1:0] r_addr;
  logic [AXI_LEN_BITS-1:0]   r_cnt;
  logic [AXI_LEN_BITS-1:0]   r_len;
  logic                      r_fixed;
  logic                      r_past;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_fixed <= 1'b0;
      r_past  <= 1'b0;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_cnt   <= '0;
      r_len   <= i_len;
      r_fixed <= (i_burst == BURST_FIXED);  // reserved encodings behave as INCR
      r_past  <= 1'b0;
    end else if (i_adv) begin
      if (!r_fixed) r_addr <= r_addr + 1'b1;  // wraps at 2^SRAM_ADDR_BITS
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      // Sticky: the counter saturates, so it alone cannot tell overrun beats apart.
      if (o_last_exp) r_past <= 1'b1;
    end
  end

  assign o_addr     = r_addr;
  assign o_last_exp = (r_cnt == r_len) && !r_past;
  assign o_past_len = r_past;

endmodule

// File: rtl/slave_write.sv
// AXI write responder for one SRAM slave: one AW burst, W beats straight to the SRAM port, one B.
// Latency: SRAM write combinational in the W handshake cycle; BVALID the cycle after the WLAST beat.
// Backpressure: AWREADY only in IDLE, WREADY only in DATA; B held stable until BREADY.
// Ports: AW*/W*/B* AXI write channels; CS/WEB(active-low)/A/DI SRAM word port; slave_id = region tag.
// Optional: define SLAVE_WRITE_DECERR_EN to reject bursts outside {8'h00, slave_id} with DECERR.
module slave_write
  import axi_slave_pkg::*;
#(
  parameter int SRAM_ADDR_BITS = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_IDS_BITS-1:0]   AWID,
  input  logic [AXI_ADDR_BITS-1:0]  AWADDR,
  input  logic [AXI_LEN_BITS-1:0]   AWLEN,
  input  logic [AXI_SIZE_BITS-1:0]  AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [AXI_DATA_BITS-1:0]  WDATA,
  input  logic [3:0]                WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [AXI_IDS_BITS-1:0]   BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic                      CS,
  output logic [3:0]                WEB,
  output logic [SRAM_ADDR_BITS-1:0] A,
  output logic [31:0]               DI,
  input  logic [7:0]                slave_id
);

  state_t r_state, w_next;
  logic   r_out_en;    // holds AWREADY low until the first edge after reset release
  logic   r_size_err, r_slv_err, r_dec_err;
  logic [AXI_IDS_BITS-1:0] r_bid;

  logic w_aw_hs, w_w_hs, w_we, w_last_exp, w_past_len, w_dec_hit;
  logic [SRAM_ADDR_BITS-1:0] w_addr;
  logic w_unused_bits;

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;

`ifdef SLAVE_WRITE_DECERR_EN
  assign w_dec_hit = (AWADDR[31:16] != {8'h00, slave_id});
`else
  assign w_dec_hit = 1'b0;
`endif

  // Byte-offset bits and region bits not used for the SRAM word address.
  assign w_unused_bits = ^{AWADDR[1:0], AWADDR[AXI_ADDR_BITS-1:SRAM_ADDR_BITS+2], slave_id};

  wburst_addr_gen #(.SRAM_ADDR_BITS(SRAM_ADDR_BITS)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_aw_hs),
    .i_addr    (AWADDR[SRAM_ADDR_BITS+1:2]),
    .i_len     (AWLEN),
    .i_burst   (AWBURST),
    .i_adv     (w_w_hs),
    .o_addr    (w_addr),
    .o_last_exp(w_last_exp),
    .o_past_len(w_past_len)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_out_en <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_aw_hs) w_next = DATA;
      DATA:    if (w_w_hs && WLAST) w_next = RESP;
      RESP:    if (BREADY) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    CS      = 1'b0;
    BVALID  = 1'b0;
    case (r_state)
      IDLE:    AWREADY = r_out_en;
      DATA:    begin WREADY = 1'b1; CS = 1'b1; end
      RESP:    BVALID = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bid      <= '0;
      r_size_err <= 1'b0;
      r_slv_err  <= 1'b0;
      r_dec_err  <= 1'b0;
    end else if (w_aw_hs) begin
      r_bid      <= AWID;
      r_size_err <= (AWSIZE != SIZE_4B);
      r_slv_err  <= 1'b0;
      r_dec_err  <= w_dec_hit;
    end else if (w_w_hs && WLAST && !w_last_exp) begin
      r_slv_err  <= 1'b1;  // WLAST arrived on a beat other than AWLEN
    end
  end

  // Bad-size, decode-error and overrun beats are still accepted, just not written.
  assign w_we  = w_w_hs && !r_size_err && !r_dec_err && !w_past_len;
  assign WEB   = w_we ? ~WSTRB : 4'hF;
  assign DI    = w_w_hs ? WDATA : '0;
  assign A     = w_addr;
  assign BID   = r_bid;
  assign BRESP = BVALID ? bresp_sel(r_dec_err, r_slv_err || r_size_err) : RESP_OKAY;

endmodule

// File: tb/tb_slave_write.sv
module tb_slave_write;
  import axi_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic        CS;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [7:0]  slave_id;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  slave_write #(.SRAM_ADDR_BITS(14)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .CS(CS), .WEB(WEB), .A(A), .DI(DI), .slave_id(slave_id)
  );

  typedef struct {
    logic        awv;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [7:0]  awid;
    logic        wv;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
    logic        e_awrdy;
    logic        e_wrdy;
    logic        e_cs;
    logic [3:0]  e_web;
    logic [13:0] e_a;
    logic        e_bv;
    logic [1:0]  e_bresp;
    logic [7:0]  e_bid;
  } vec_t;

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    v.e_web = 4'hF;
    return v;
  endfunction

  function automatic vec_t idle_r();
    vec_t v = blank();
    v.e_awrdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t aw_r(input logic [31:0] addr, input logic [3:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic [7:0] id);
    vec_t v = blank();
    v.awv = 1'b1; v.awaddr = addr; v.awlen = len; v.awsize = size; v.awburst = burst; v.awid = id;
    v.e_awrdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t w_r(input logic [31:0] data, input logic [3:0] strb, input logic last,
                               input logic [3:0] eweb, input logic [13:0] ea);
    vec_t v = blank();
    v.wv = 1'b1; v.wdata = data; v.wstrb = strb; v.wlast = last;
    v.e_wrdy = 1'b1; v.e_cs = 1'b1; v.e_web = eweb; v.e_a = ea;
    return v;
  endfunction

  function automatic vec_t gap_r(input logic [13:0] ea);
    vec_t v = blank();
    v.e_wrdy = 1'b1; v.e_cs = 1'b1; v.e_a = ea;
    return v;
  endfunction

  function automatic vec_t b_r(input logic rdy, input logic [1:0] resp, input logic [7:0] id);
    vec_t v = blank();
    v.bready = rdy; v.e_bv = 1'b1; v.e_bresp = resp; v.e_bid = id;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic drive(input vec_t v);
    AWVALID = v.awv; AWADDR = v.awaddr; AWLEN = v.awlen; AWSIZE = v.awsize;
    AWBURST = v.awburst; AWID = v.awid;
    WVALID = v.wv; WDATA = v.wdata; WSTRB = v.wstrb; WLAST = v.wlast;
    BREADY = v.bready;
  endtask

  // Drive at the falling edge, check 1 time unit later, DUT state advances on the next rising edge.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".AWREADY"}, 32'(AWREADY), 32'(v.e_awrdy));
    chk({tag, ".WREADY"},  32'(WREADY),  32'(v.e_wrdy));
    chk({tag, ".CS"},      32'(CS),      32'(v.e_cs));
    chk({tag, ".WEB"},     32'(WEB),     32'(v.e_web));
    chk({tag, ".BVALID"},  32'(BVALID),  32'(v.e_bv));
    if (v.e_cs) chk({tag, ".A"}, 32'(A), 32'(v.e_a));
    if (v.e_web != 4'hF) chk({tag, ".DI"}, DI, v.wdata);
    if (v.e_bv) begin
      chk({tag, ".BRESP"}, 32'(BRESP), 32'(v.e_bresp));
      chk({tag, ".BID"},   32'(BID),   32'(v.e_bid));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".AWREADY"}, 32'(AWREADY), 32'd0);
    chk({tag, ".WREADY"},  32'(WREADY),  32'd0);
    chk({tag, ".BVALID"},  32'(BVALID),  32'd0);
    chk({tag, ".BID"},     32'(BID),     32'd0);
    chk({tag, ".BRESP"},   32'(BRESP),   32'd0);
    chk({tag, ".CS"},      32'(CS),      32'd0);
    chk({tag, ".WEB"},     32'(WEB),     32'hF);
    chk({tag, ".A"},       32'(A),       32'd0);
    chk({tag, ".DI"},      DI,           32'd0);
  endtask

`ifdef SLAVE_WRITE_DECERR_EN
  localparam logic [3:0] OUT_WEB  = 4'hF;
  localparam logic [1:0] OUT_RESP = 2'b11;
`else
  localparam logic [3:0] OUT_WEB  = 4'h0;
  localparam logic [1:0] OUT_RESP = 2'b00;
`endif

  vec_t tbl[$];

  initial begin
    slave_id = 8'h01;
    rst = 1'b0;
    drive(blank());
    #2;
    chk_reset("por");

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel.AWREADY_before_edge", 32'(AWREADY), 32'd0);

    // Single beat
    tbl.push_back(idle_r());
    tbl.push_back(aw_r(32'h0001_0010, 4'd0, 3'b010, 2'b01, 8'h05));
    tbl.push_back(w_r(32'hDEAD_BEEF, 4'hF, 1'b1, 4'h0, 14'h004));
    tbl.push_back(b_r(1'b1, 2'b00, 8'h05));
    tbl.push_back(idle_r());
    // INCR x4, half-word strobes, WVALID gap after beat 2
    tbl.push_back(aw_r(32'h0001_0010, 4'd3, 3'b010, 2'b01, 8'h03));
    tbl.push_back(w_r(32'h1111_1111, 4'b0011, 1'b0, 4'b1100, 14'h004));
    tbl.push_back(w_r(32'h2222_2222, 4'b0011, 1'b0, 4'b1100, 14'h005));
    tbl.push_back(gap_r(14'h006));
    tbl.push_back(w_r(32'h3333_3333, 4'b0011, 1'b0, 4'b1100, 14'h006));
    tbl.push_back(w_r(32'h4444_4444, 4'b0011, 1'b1, 4'b1100, 14'h007));
    tbl.push_back(b_r(1'b1, 2'b00, 8'h03));
    // Word address wrap 0x3FFF -> 0x0000
    tbl.push_back(aw_r(32'h0001_FFFC, 4'd1, 3'b010, 2'b01, 8'h07));
    tbl.push_back(w_r(32'hA5A5_0001, 4'hF, 1'b0, 4'h0, 14'h3FFF));
    tbl.push_back(w_r(32'hA5A5_0002, 4'hF, 1'b1, 4'h0, 14'h0000));
    tbl.push_back(b_r(1'b1, 2'b00, 8'h07));
    // Early WLAST on beat 1 of AWLEN=3
    tbl.push_back(aw_r(32'h0001_0100, 4'd3, 3'b010, 2'b01, 8'h02));
    tbl.push_back(w_r(32'h0000_0100, 4'hF, 1'b0, 4'h0, 14'h040));
    tbl.push_back(w_r(32'h0000_0101, 4'hF, 1'b1, 4'h0, 14'h041));
    tbl.push_back(b_r(1'b1, 2'b10, 8'h02));
    // Bad AWSIZE: accepted, nothing written
    tbl.push_back(aw_r(32'h0001_0020, 4'd1, 3'b001, 2'b01, 8'h04));
    tbl.push_back(w_r(32'h0000_0200, 4'hF, 1'b0, 4'hF, 14'h008));
    tbl.push_back(w_r(32'h0000_0201, 4'hF, 1'b1, 4'hF, 14'h009));
    tbl.push_back(b_r(1'b1, 2'b10, 8'h04));
    // Beat past AWLEN=0: not written, WLAST mismatch
    tbl.push_back(aw_r(32'h0001_0030, 4'd0, 3'b010, 2'b01, 8'h06));
    tbl.push_back(w_r(32'h0000_0300, 4'hF, 1'b0, 4'h0, 14'h00C));
    tbl.push_back(w_r(32'h0000_0301, 4'hF, 1'b1, 4'hF, 14'h00D));
    tbl.push_back(b_r(1'b1, 2'b10, 8'h06));
    // FIXED burst keeps the address
    tbl.push_back(aw_r(32'h0001_0044, 4'd1, 3'b010, 2'b00, 8'h08));
    tbl.push_back(w_r(32'h0000_0400, 4'b1000, 1'b0, 4'b0111, 14'h011));
    tbl.push_back(w_r(32'h0000_0401, 4'b0001, 1'b1, 4'b1110, 14'h011));
    tbl.push_back(b_r(1'b1, 2'b00, 8'h08));
    tbl.push_back(idle_r());

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // BREADY held low for 5 cycles: B stays put, no new AW accepted
    apply("bhold.aw", aw_r(32'h0001_0050, 4'd0, 3'b010, 2'b01, 8'h0C));
    apply("bhold.w",  w_r(32'h0BAD_F00D, 4'hF, 1'b1, 4'h0, 14'h014));
    for (int k = 0; k < 5; k++) begin
      vec_t v = b_r(1'b0, 2'b00, 8'h0C);
      v.awv = 1'b1; v.awaddr = 32'h0001_0060; v.awid = 8'hEE; v.awsize = 3'b010;
      apply($sformatf("bhold.wait%0d", k), v);
    end
    apply("bhold.b", b_r(1'b1, 2'b00, 8'h0C));
    apply("bhold.idle", idle_r());

    // Out-of-region address: DECERR when region checking is built in, plain write otherwise
    apply("region.aw", aw_r(32'h0002_0000, 4'd0, 3'b010, 2'b01, 8'h0D));
    apply("region.w",  w_r(32'hCAFE_F00D, 4'hF, 1'b1, OUT_WEB, 14'h000));
    apply("region.b",  b_r(1'b1, OUT_RESP, 8'h0D));

    // Reset asserted mid-burst during beat 2 of 4
    apply("rstmid.aw", aw_r(32'h0001_0040, 4'd3, 3'b010, 2'b01, 8'h0A));
    apply("rstmid.w1", w_r(32'h5555_0001, 4'hF, 1'b0, 4'h0, 14'h010));
    apply("rstmid.w2", w_r(32'h5555_0002, 4'hF, 1'b0, 4'h0, 14'h011));
    #1;
    rst = 1'b0;
    #1;
    chk_reset("rstmid.asserted");
    drive(blank());
    @(negedge clk);
    chk_reset("rstmid.held");
    rst = 1'b1;
    #1;
    chk("rstmid.AWREADY_before_edge", 32'(AWREADY), 32'd0);
    apply("rstmid.after0", idle_r());
    apply("rstmid.after1", idle_r());
    apply("rstmid.after2", idle_r());

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
